// File: rtl/qlf_arith_pkg.sv
// Shared sizing helpers for the segmented carry-chain arithmetic blocks.
// A WIDTH-bit operation is cut into SEG_W-bit segments; the last one may be narrower.
package qlf_arith_pkg;

  localparam int MAX_SEG_W = 64;

  function automatic int num_seg(input int width, input int seg_w);
    return (width + seg_w - 1) / seg_w;
  endfunction

  function automatic int last_seg_w(input int width, input int seg_w);
    return width - (num_seg(width, seg_w) - 1) * seg_w;
  endfunction

endpackage

// File: rtl/qlf_seg_add_stage.sv
// One pipeline stage of the segmented adder: a SEG_W-bit carry-chain slice plus
// the valid/hold register and skew registers for the not-yet-processed operand bits.
module qlf_seg_add_stage #(
  parameter int SEG_W   = 8,
  parameter int LO_W    = 0,
  parameter int REM_W   = 24,
  parameter bit IS_LAST = 1'b0
) (
  input  logic                               C,
  input  logic                               R,
  input  logic                               i_load,
  input  logic                               i_v,
  input  logic                               i_cin,
  input  logic [SEG_W+REM_W-1:0]             i_a,
  input  logic [SEG_W+REM_W-1:0]             i_b,
  input  logic [(LO_W > 0 ? LO_W : 1)-1:0]   i_lo,
  output logic                               o_v,
  output logic                               o_c,
  output logic                               o_ovf,
  output logic [LO_W+SEG_W-1:0]              o_done,
  output logic [(REM_W > 0 ? REM_W : 1)-1:0] o_a,
  output logic [(REM_W > 0 ? REM_W : 1)-1:0] o_b
);

  localparam int REM_P = (REM_W > 0) ? REM_W : 1;

  logic [SEG_W:0]          w_sum;
  logic [SEG_W-1:0]        w_s;
  logic                    w_c;
  logic                    w_cmsb;
  logic [LO_W+SEG_W-1:0]   w_done;
  logic [REM_P-1:0]        w_a_rem;
  logic [REM_P-1:0]        w_b_rem;

  logic                    r_v;
  logic                    r_c;
  logic                    r_ovf;
  logic [LO_W+SEG_W-1:0]   r_done;
  logic [REM_P-1:0]        r_a;
  logic [REM_P-1:0]        r_b;

  // Plain '+' so the segment maps onto a single SEG_W-cell carry chain.
  assign w_sum  = {1'b0, i_a[SEG_W-1:0]} + {1'b0, i_b[SEG_W-1:0]} + {{SEG_W{1'b0}}, i_cin};
  assign w_s    = w_sum[SEG_W-1:0];
  assign w_c    = w_sum[SEG_W];
  // Carry into the segment MSB recovered from the sum bit, without a second adder.
  assign w_cmsb = i_a[SEG_W-1] ^ i_b[SEG_W-1] ^ w_s[SEG_W-1];

  if (LO_W > 0) begin : g_lo
    assign w_done = {w_s, i_lo};
  end else begin : g_no_lo
    logic w_lo_unused;
    assign w_lo_unused = ^i_lo;
    assign w_done      = w_s;
  end

  if (REM_W > 0) begin : g_rem
    assign w_a_rem = i_a[SEG_W+REM_W-1:SEG_W];
    assign w_b_rem = i_b[SEG_W+REM_W-1:SEG_W];
  end else begin : g_no_rem
    assign w_a_rem = '0;
    assign w_b_rem = '0;
  end

  always_ff @(posedge C) begin
    if (R) begin
      r_v    <= 1'b0;
      r_c    <= 1'b0;
      r_ovf  <= 1'b0;
      r_done <= '0;
      r_a    <= '0;
      r_b    <= '0;
    end else if (i_load) begin
      r_v <= i_v;
      if (i_v) begin
        r_c    <= w_c;
        r_done <= w_done;
        r_a    <= w_a_rem;
        r_b    <= w_b_rem;
        r_ovf  <= IS_LAST ? (w_c ^ w_cmsb) : 1'b0;
      end
    end
  end

  assign o_v    = r_v;
  assign o_c    = r_c;
  assign o_ovf  = r_ovf;
  assign o_done = r_done;
  assign o_a    = r_a;
  assign o_b    = r_b;

endmodule

// File: rtl/qlf_seg_pipe_adder.sv
// Wide add/subtract split into SEG_W-bit segments, one segment per pipeline stage,
// with registered inter-segment carries and a bubble-collapsing valid/ready chain.
module qlf_seg_pipe_adder
  import qlf_arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             C,
  input  logic             R,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             co,
  output logic             ovf
);

  localparam int NUM_SEG = num_seg(WIDTH, SEG_W);
  localparam int LAST_W  = last_seg_w(WIDTH, SEG_W);

  logic [WIDTH-1:0]   w_bb;
  logic [NUM_SEG-1:0] w_adv;
  logic [NUM_SEG-1:0] w_v;
  logic [NUM_SEG-1:0] w_c;
  logic [NUM_SEG-1:0] w_ovf;

  // Subtraction as a + ~b + 1: the +1 enters as the stage-0 carry.
  assign w_bb = sub ? ~b : b;

  // Valid/ready: a beat moves on an edge where valid & ready are both high; a
  // producer holding valid keeps its data stable until ready. Stage k may load
  // when it or any stage below it is empty, or the consumer is taking a result.
  always_comb begin
    for (int k = 0; k < NUM_SEG; k++) begin
      w_adv[k] = out_ready;
      for (int j = k; j < NUM_SEG; j++) begin
        if (!w_v[j]) w_adv[k] = 1'b1;
      end
    end
  end

  assign in_ready = w_adv[0];

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
    localparam int LO_W  = k * SEG_W;
    localparam int SEG_K = (k == NUM_SEG - 1) ? LAST_W : SEG_W;
    localparam int REM_W = WIDTH - LO_W - SEG_K;

    logic [SEG_K+REM_W-1:0]             w_a_in;
    logic [SEG_K+REM_W-1:0]             w_b_in;
    logic [(LO_W > 0 ? LO_W : 1)-1:0]   w_lo_in;
    logic                               w_v_in;
    logic                               w_cin;
    logic [LO_W+SEG_K-1:0]              w_done;
    logic [(REM_W > 0 ? REM_W : 1)-1:0] w_a_rem;
    logic [(REM_W > 0 ? REM_W : 1)-1:0] w_b_rem;

    if (k == 0) begin : g_first
      assign w_a_in  = a;
      assign w_b_in  = w_bb;
      assign w_lo_in = '0;
      assign w_v_in  = in_valid & w_adv[0];
      assign w_cin   = sub;
    end else begin : g_next
      assign w_a_in  = g_stage[k-1].w_a_rem;
      assign w_b_in  = g_stage[k-1].w_b_rem;
      assign w_lo_in = g_stage[k-1].w_done;
      assign w_v_in  = w_v[k-1];
      assign w_cin   = w_c[k-1];
    end

    qlf_seg_add_stage #(
      .SEG_W   (SEG_K),
      .LO_W    (LO_W),
      .REM_W   (REM_W),
      .IS_LAST (k == NUM_SEG - 1)
    ) u_stage (
      .C      (C),
      .R      (R),
      .i_load (w_adv[k]),
      .i_v    (w_v_in),
      .i_cin  (w_cin),
      .i_a    (w_a_in),
      .i_b    (w_b_in),
      .i_lo   (w_lo_in),
      .o_v    (w_v[k]),
      .o_c    (w_c[k]),
      .o_ovf  (w_ovf[k]),
      .o_done (w_done),
      .o_a    (w_a_rem),
      .o_b    (w_b_rem)
    );
  end

  assign out_valid = w_v[NUM_SEG-1];
  assign y         = g_stage[NUM_SEG-1].w_done;
  assign co        = w_c[NUM_SEG-1];
  assign ovf       = w_ovf[NUM_SEG-1];

  // The final stage has no remaining slices, and only its overflow flag is live.
  logic w_unused;
  assign w_unused = ^{g_stage[NUM_SEG-1].w_a_rem, g_stage[NUM_SEG-1].w_b_rem, w_ovf};

endmodule

// File: doc/qlf_seg_pipe_adder.md
Name: qlf_seg_pipe_adder

Overview:
- Wide add/subtract unit that splits a WIDTH-bit operation into SEG_W-bit carry-chain segments.
- One segment is computed per pipeline stage. The inter-segment carry is registered, so no chain exceeds SEG_W adder cells.
- Sits directly upstream of the `$alu` carry-chain techmap: each stage's segment sum is written as a plain `+` so that mapping lands it on the `adder` chain.
- Used for wide counters and accumulators that would otherwise break timing on a full-width chain.

Parameters:
- WIDTH, 32, operand and result width (>=2).
- SEG_W, 8, bits per pipeline segment (1..WIDTH).
- NUM_SEG, derived localparam = ceil(WIDTH/SEG_W); this equals both the latency and the capacity.

Ports:
- C  input  1  clock; all state updates on the rising edge.
- R  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  stage 0 can accept a beat.
- a  input  WIDTH  operand A (unsigned / two's complement).
- b  input  WIDTH  operand B.
- sub  input  1  1: y = a - b; 0: y = a + b.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- y  output  WIDTH  sum/difference modulo 2^WIDTH.
- co  output  1  carry out of the MSB. For sub, co = 1 means no borrow.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (R=1 at an edge): all stage valids = 0, all data registers cleared. Outputs are then out_valid=0, y=0, co=0, ovf=0. Any in-flight beats are discarded with no partial output. R has priority over every other event in the same cycle.
- Entry transform: bb = sub ? ~b : b; cin0 = sub.
- Stage k (k = 0..NUM_SEG-1) holds:
  - v[k];
  - done bits [min((k+1)*SEG_W, WIDTH)-1 : 0] of the result;
  - carry c[k] out of segment k;
  - the unprocessed upper slices of a and bb;
  - ovf candidate: in the last stage only, carry into the MSB.
- Stage k computes segment k from stage k-1's registered carry. Stage 0 uses cin0 and the live inputs.
- Last segment width = WIDTH - (NUM_SEG-1)*SEG_W; this may be smaller than SEG_W.
- Handshake, per-stage bubble collapse:
  - adv[NUM_SEG-1] = out_ready | ~v[NUM_SEG-1]
  - adv[k] = ~v[k] | adv[k+1]
  - in_ready = adv[0], computed combinationally from the downstream ready chain.
  - out_ready must not combinationally depend on in_valid.
- Stage k loads from stage k-1 when adv[k]. Its valid becomes v[k-1] (stage 0: in_valid & in_ready). Otherwise the stage holds its contents.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+NUM_SEG-1. Each stage adds one edge.
- Throughput: 1 beat/cycle with out_ready=1. Capacity = NUM_SEG beats; with out_ready=0, in_ready falls once all stages are valid.
- y/co/ovf are driven from the last stage registers. They are stable while out_valid=1 and out_ready=0.
- Simultaneous accept and drain on a full pipe is allowed: in_ready=1 when out_ready=1.
- SEG_W >= WIDTH: NUM_SEG=1, a single registered full-width adder with latency 1.

Decomposition:
- Shared package/header `qlf_arith_pkg`:
  - function `num_seg(width, seg_w)`;
  - function `last_seg_w(width, seg_w)`;
  - localparam for maximum supported SEG_W (64).
- Sub-module `qlf_seg_add_stage`, parameterised by the segment width and the remaining-slice width. It contains:
  - the segment adder: `{c_out, s} = a_seg + b_seg + c_in`;
  - the stage valid/hold register and the skew registers.
- Top level: generate loop over NUM_SEG stages, plus the entry inversion and the handshake chain.

Test Plan (WIDTH=32, SEG_W=8 unless stated):
- 0xFFFFFFFF + 0x00000001, sub=0, out_ready=1 -> after latency 4: y=0x00000000, co=1, ovf=0; exactly one out_valid pulse.
- 0x7FFFFFFF + 0x00000001 -> y=0x80000000, co=0, ovf=1. Also 5 - 7 with sub=1 -> y=0xFFFFFFFE, co=0, ovf=0.
- Stream 6 beats back-to-back with out_ready=0 from the start:
  - in_ready deasserts after 4 accepts;
  - then out_ready=1 -> 6 results emitted in order, no loss or duplication;
  - y is held constant while stalled.
- Random out_ready and in_valid (10k beats) vs reference model a ± b -> all y/co/ovf match, order preserved.
- Assert R for 1 cycle with 3 beats in flight -> next cycle out_valid=0, y=0, in_ready=1; the following beat 3+4 gives y=7 at latency 4.
- WIDTH=20, SEG_W=8 (NUM_SEG=3, last segment 4 bits):
  - 0xFFFFF + 1 -> y=0x00000, co=1 after latency 3;
  - WIDTH=8, SEG_W=8: 0x80 - 0x01 -> y=0x7F, ovf=1, co=1 after latency 1.
